mem_access_stage: RTL and testbench

- Memory stage directly downstream of the ALU/execute stage.
- Consumes the 32-bit ALU result as a data address, or as pass-through data for non-memory ops.
- Performs byte/half/word loads and stores over a req/ack data bus.
- Delivers write-back data, with a one-cycle valid pulse, to the register-file write port.

---
 rtl/mem_access_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage after execute. Passes ALU results through,
// or performs byte/half/word loads and stores over a req/ack bus, then
// emits one write-back pulse per accepted operation.
// Optional build macro: MEM_TIMEOUT_EN adds a bus-wait timeout that ends a
// stalled transfer with a fault after TIMEOUT_CYCLES REQ cycles.
module mem_access_stage #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic        is_load;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        sign_q;
  logic [31:0] rdata_q;
  logic        err_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // Half must sit on an even byte, word on a multiple of four.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   calc_be = 4'b0001 << a;
      2'b01:   calc_be = a[1] ? 4'b1100 : 4'b0011;
      default: calc_be = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every lane carries it; bus_be picks the lane.
  function automatic logic [31:0] calc_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   calc_wdata = {4{d[7:0]}};
      2'b01:   calc_wdata = {2{d[15:0]}};
      default: calc_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] lane,
                                               input logic sx, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   load_extract = {{24{sx & b[7]}}, b};
      2'b01:   load_extract = {{16{sx & h[15]}}, h};
      default: load_extract = rd;
    endcase
  endfunction

  assign in_ready = (state == IDLE);

  // Stage FSM: accept in IDLE, hold the bus in REQ, deliver the result from RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'd0;
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      out_data  <= 32'd0;
      is_load   <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      sign_q    <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_read && !mem_write) begin
              out_valid <= 1'b1;
              out_fault <= 1'b0;
              out_data  <= alu_result;
            end else if ((mem_read && mem_write) || size == 2'b11 ||
                         misaligned(size, alu_result[1:0])) begin
              out_valid <= 1'b1;
              out_fault <= 1'b1;
              out_data  <= 32'd0;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
              bus_be    <= calc_be(size, alu_result[1:0]);
              bus_wdata <= calc_wdata(size, store_data);
              is_load   <= mem_read;
              size_q    <= size;
              lane_q    <= alu_result[1:0];
              sign_q    <= sign_ext;
`ifdef MEM_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata_q <= bus_rdata;
            err_q   <= bus_err;
            state   <= RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // Zeroed read data makes the faulted result come out as 0.
            bus_req <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          out_valid <= 1'b1;
          out_fault <= err_q;
          out_data  <= is_load ? load_extract(size_q, lane_q, sign_q, rdata_q) : 32'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage. Define MEM_TIMEOUT_EN for both
// files to exercise the timeout build (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_fault;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ADDR_W(32),
`ifdef MEM_TIMEOUT_EN
    .TIMEOUT_CYCLES(4)
`else
    .TIMEOUT_CYCLES(255)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_fault(out_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic sx);
    in_valid   = 1'b1;
    alu_result = a;
    store_data = sd;
    mem_read   = rd;
    mem_write  = wr;
    size       = sz;
    sign_ext   = sx;
    step();
    in_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; sign_ext = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    step();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Pass-through, then back-to-back second pass-through.
    issue(32'h0000_1234, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_data", out_data, 32'h0000_1234);
    check("pt_fault", 32'(out_fault), 32'd0);
    check("pt_no_req", 32'(bus_req), 32'd0);
    issue(32'hCAFE_0001, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    check("pt2_data", out_data, 32'hCAFE_0001);
    step();
    check("pt_pulse_end", 32'(out_valid), 32'd0);

    // Signed byte load at 0x103, ack after two wait cycles.
    issue(32'h0000_0103, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    check("lb_req", 32'(bus_req), 32'd1);
    check("lb_addr", bus_addr, 32'h0000_0100);
    check("lb_be", 32'(bus_be), 32'b1000);
    check("lb_we", 32'(bus_we), 32'd0);
    check("lb_ready", 32'(in_ready), 32'd0);
    step();
    check("lb_wait1_req", 32'(bus_req), 32'd1);
    step();
    check("lb_wait2_req", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h80FF_0000;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check("lb_req_drop", 32'(bus_req), 32'd0);
    check("lb_not_yet", 32'(out_valid), 32'd0);
    step();
    check("lb_valid", 32'(out_valid), 32'd1);
    check("lb_data", out_data, 32'hFFFF_FF80);
    check("lb_fault", 32'(out_fault), 32'd0);
    step();
    check("lb_pulse_end", 32'(out_valid), 32'd0);

    // Half store at 0x202, same-cycle ack.
    issue(32'h0000_0202, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b01, 1'b0);
    check("sh_we", 32'(bus_we), 32'd1);
    check("sh_be", 32'(bus_be), 32'b1100);
    check("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    check("sh_addr", bus_addr, 32'h0000_0200);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    check("sh_valid", 32'(out_valid), 32'd1);
    check("sh_fault", 32'(out_fault), 32'd0);
    check("sh_data", out_data, 32'd0);

    // Byte store lane 1 replicates the low byte.
    issue(32'h0000_0011, 32'h1234_56A5, 1'b0, 1'b1, 2'b00, 1'b0);
    check("sb_be", 32'(bus_be), 32'b0010);
    check("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    check("sb_valid", 32'(out_valid), 32'd1);

    // Fault cases: misaligned word, read+write, reserved size.
    issue(32'h0000_0101, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    check("mis_valid", 32'(out_valid), 32'd1);
    check("mis_fault", 32'(out_fault), 32'd1);
    check("mis_data", out_data, 32'd0);
    check("mis_no_req", 32'(bus_req), 32'd0);
    issue(32'h0000_0100, 32'd0, 1'b1, 1'b1, 2'b10, 1'b0);
    check("rw_fault", 32'(out_fault), 32'd1);
    check("rw_no_req", 32'(bus_req), 32'd0);
    issue(32'h0000_0100, 32'd0, 1'b1, 1'b0, 2'b11, 1'b0);
    check("sz11_fault", 32'(out_fault), 32'd1);
    check("sz11_valid", 32'(out_valid), 32'd1);
    issue(32'h0000_0201, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    check("mish_fault", 32'(out_fault), 32'd1);

    // Word load with bus error.
    issue(32'h0000_0300, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    check("lwe_be", 32'(bus_be), 32'b1111);
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0; bus_err = 1'b0;
    step();
    check("lwe_valid", 32'(out_valid), 32'd1);
    check("lwe_fault", 32'(out_fault), 32'd1);

    // Unsigned half load from upper half.
    issue(32'h0000_0402, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'h8001_7FFF;
    step();
    bus_ack = 1'b0;
    step();
    check("lhu_data", out_data, 32'h0000_8001);
    check("lhu_fault", 32'(out_fault), 32'd0);

    // Stray ack in IDLE is ignored.
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    check("stray_ack_valid", 32'(out_valid), 32'd0);
    check("stray_ack_ready", 32'(in_ready), 32'd1);

    // Reset during REQ drops bus_req immediately, no result afterwards.
    issue(32'h0000_0500, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    check("rr_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_req_drop", 32'(bus_req), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rr_no_valid", 32'(out_valid), 32'd0);
    check("rr_ready", 32'(in_ready), 32'd1);
    step();
    check("rr_no_valid2", 32'(out_valid), 32'd0);

    // Unacknowledged load.
    issue(32'h0000_0600, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
`ifdef MEM_TIMEOUT_EN
    step();
    step();
    step();
    check("tmo_req_c4", 32'(bus_req), 32'd1);
    step();
    check("tmo_req_drop", 32'(bus_req), 32'd0);
    step();
    check("tmo_valid", 32'(out_valid), 32'd1);
    check("tmo_fault", 32'(out_fault), 32'd1);
    check("tmo_data", out_data, 32'd0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (!bus_req) begin
        check("hang_req", 32'(bus_req), 32'd1);
        break;
      end
      step();
    end
    check("hang_req_end", 32'(bus_req), 32'd1);
    check("hang_no_valid", 32'(out_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
